// File: rtl/dma_pkg.sv
`default_nettype none
// +-------------------------------------------------------------+
// | dma_pkg: register map, bit positions, FSM states, ROM check  |
// | rev 1.0                                                      |
// +-------------------------------------------------------------+
package dma_pkg;

  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_DST    = 3'd1;
  localparam logic [2:0] REG_LEN    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERROR   = 2;
  localparam int STAT_ABORTED = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_e;

  // The ROM window is not reachable from the DMA master port.
  function automatic logic is_rom_addr(input logic [31:0] addr);
    return addr[30:29] == 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_controller_if.sv
`default_nettype none
// +-------------------------------------------------------------+
// | dma_controller_if: MMIO slave channels + DMA master channels |
// | rev 1.0                                                      |
// +-------------------------------------------------------------+
interface dma_controller_if;
  logic [31:0] regWriteAddress;
  logic        regWriteValid;
  logic        regWriteReady;
  logic [31:0] regWriteData;
  logic        regWriteValidData;
  logic        regWriteReadyData;
  logic [31:0] regReadAddress;
  logic        regReadValid;
  logic        regReadReady;
  logic [31:0] regReadData;
  logic        regReadValidData;
  logic        regReadReadyData;

  logic [31:0] dmaAxiWriteAddress;
  logic        dmaAxiWriteValid;
  logic        dmaAxiWriteReady;
  logic [31:0] dmaAxiWriteData;
  logic        dmaAxiWriteValidData;
  logic        dmaAxiWriteReadyData;
  logic [31:0] dmaAxiReadAddress;
  logic        dmaAxiReadValid;
  logic        dmaAxiReadReady;
  logic [31:0] dmaAxiReadData;
  logic        dmaAxiReadValidData;
  logic        dmaAxiReadReadyData;

  logic        doneIrq;

  // Engine side
  modport slave (
    input  regWriteAddress, regWriteValid, regWriteData, regWriteValidData,
    input  regReadAddress, regReadValid, regReadReadyData,
    output regWriteReady, regWriteReadyData, regReadReady, regReadData, regReadValidData,
    output dmaAxiWriteAddress, dmaAxiWriteValid, dmaAxiWriteData, dmaAxiWriteValidData,
    output dmaAxiReadAddress, dmaAxiReadValid, dmaAxiReadReadyData,
    input  dmaAxiWriteReady, dmaAxiWriteReadyData, dmaAxiReadReady,
    input  dmaAxiReadData, dmaAxiReadValidData,
    output doneIrq
  );

  // CPU / interconnect side
  modport master (
    output regWriteAddress, regWriteValid, regWriteData, regWriteValidData,
    output regReadAddress, regReadValid, regReadReadyData,
    input  regWriteReady, regWriteReadyData, regReadReady, regReadData, regReadValidData,
    input  dmaAxiWriteAddress, dmaAxiWriteValid, dmaAxiWriteData, dmaAxiWriteValidData,
    input  dmaAxiReadAddress, dmaAxiReadValid, dmaAxiReadReadyData,
    output dmaAxiWriteReady, dmaAxiWriteReadyData, dmaAxiReadReady,
    output dmaAxiReadData, dmaAxiReadValidData,
    input  doneIrq
  );
endinterface
`default_nettype wire

// File: rtl/dma_regfile.sv
`default_nettype none
// +-------------------------------------------------------------+
// | dma_regfile: MMIO decode, config/status storage, W1C, pulses |
// | rev 1.0                                                      |
// +-------------------------------------------------------------+
module dma_regfile
  import dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clock,
  input  logic             resetActiveLow,
  input  logic             wr_en,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [31:0]      rd_addr,
  output logic [31:0]      rd_data,
  input  logic             busy,
  input  logic [LEN_W-1:0] remaining,
  input  logic             set_done,
  input  logic             set_error,
  input  logic             set_aborted,
  input  logic             clr_status,
  output logic [31:0]      src,
  output logic [31:0]      dst,
  output logic [LEN_W-1:0] len,
  output logic             start,
  output logic             abort,
  output logic             done_irq
);

  logic [31:0]      src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             irq_en_q, irq_en_d, done_q, done_d;
  logic             error_q, error_d, aborted_q, aborted_d;
  logic [2:0]       wr_sel, rd_sel;
  logic             unused_addr_bits;

  assign wr_sel = wr_addr[4:2];
  assign rd_sel = rd_addr[4:2];
  assign unused_addr_bits = &{1'b0, wr_addr[31:5], wr_addr[1:0], rd_addr[31:5], rd_addr[1:0]};

  // Pulses are combinational so the FSM acts on the same edge as the write.
  assign start = wr_en && (wr_sel == REG_CTRL) && wr_data[CTRL_START];
  assign abort = wr_en && (wr_sel == REG_CTRL) && wr_data[CTRL_ABORT];

  always_comb begin
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    error_d   = error_q;
    aborted_d = aborted_q;
    if (wr_en) begin
      case (wr_sel)
        REG_SRC:    if (!busy) src_d = wr_data;
        REG_DST:    if (!busy) dst_d = wr_data;
        REG_LEN:    if (!busy) len_d = wr_data[LEN_W-1:0];
        REG_CTRL:   irq_en_d = wr_data[CTRL_IRQ_EN];
        REG_STATUS: begin
          done_d    = done_q    & ~wr_data[STAT_DONE];
          error_d   = error_q   & ~wr_data[STAT_ERROR];
          aborted_d = aborted_q & ~wr_data[STAT_ABORTED];
        end
        default: ;
      endcase
    end
    if (clr_status) begin
      done_d    = 1'b0;
      error_d   = 1'b0;
      aborted_d = 1'b0;
    end
    // Engine events win over a software clear in the same cycle.
    if (set_done)    done_d    = 1'b1;
    if (set_error)   error_d   = 1'b1;
    if (set_aborted) aborted_d = 1'b1;
  end

  always_comb begin
    rd_data = 32'h0;
    case (rd_sel)
      REG_SRC:    rd_data = src_q;
      REG_DST:    rd_data = dst_q;
      REG_LEN:    rd_data = 32'(len_q);
      REG_CTRL:   rd_data[CTRL_IRQ_EN] = irq_en_q;
      REG_STATUS: begin
        rd_data[31:16]        = 16'(remaining);
        rd_data[STAT_BUSY]    = busy;
        rd_data[STAT_DONE]    = done_q;
        rd_data[STAT_ERROR]   = error_q;
        rd_data[STAT_ABORTED] = aborted_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetActiveLow) begin
    if (!resetActiveLow) begin
      src_q     <= 32'h0;
      dst_q     <= 32'h0;
      len_q     <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      error_q   <= error_d;
      aborted_q <= aborted_d;
    end
  end

  assign src      = src_q;
  assign dst      = dst_q;
  assign len      = len_q;
  assign done_irq = done_q && irq_en_q;

endmodule
`default_nettype wire

// File: rtl/dma_controller.sv
`default_nettype none
// +-------------------------------------------------------------+
// | dma_controller: single-channel word-copy DMA engine          |
// | rev 1.0                                                      |
// +-------------------------------------------------------------+
module dma_controller
  import dma_pkg::*;
#(
  parameter int GRANT_WAIT = 1,
  parameter int LEN_W      = 16
) (
  input  logic             clock,
  input  logic             resetActiveLow,
  dma_controller_if.slave  bus
);

  localparam int             GW_W    = (GRANT_WAIT > 0) ? $clog2(GRANT_WAIT + 1) : 1;
  localparam logic [GW_W-1:0] GW_LOAD = GW_W'(GRANT_WAIT);

  dma_state_e       state_q, state_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d, data_q, data_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [GW_W-1:0]  grant_q, grant_d;
  logic             abort_q, abort_d;

  logic [31:0]      cfg_src, cfg_dst;
  logic [LEN_W-1:0] cfg_len;
  logic             start, abort, busy;
  logic             set_done, set_error, set_aborted, clr_status;
  logic             read_done, write_done, bad_cfg;
  logic             unused_inputs;

  assign unused_inputs = &{1'b0, bus.regWriteValidData, bus.regReadValid, bus.regReadReadyData};

  dma_regfile #(.LEN_W(LEN_W)) u_regfile (
    .clock          (clock),
    .resetActiveLow (resetActiveLow),
    .wr_en          (bus.regWriteValid),
    .wr_addr        (bus.regWriteAddress),
    .wr_data        (bus.regWriteData),
    .rd_addr        (bus.regReadAddress),
    .rd_data        (bus.regReadData),
    .busy           (busy),
    .remaining      (rem_q),
    .set_done       (set_done),
    .set_error      (set_error),
    .set_aborted    (set_aborted),
    .clr_status     (clr_status),
    .src            (cfg_src),
    .dst            (cfg_dst),
    .len            (cfg_len),
    .start          (start),
    .abort          (abort),
    .done_irq       (bus.doneIrq)
  );

  assign busy       = (state_q == READ) || (state_q == WRITE);
  assign bad_cfg    = is_rom_addr(cfg_src) || (cfg_src[1:0] != 2'b00) || (cfg_dst[1:0] != 2'b00);
  // The grant-wait countdown gates only the read side.
  assign read_done  = bus.dmaAxiReadReady && bus.dmaAxiReadValidData && (grant_q == '0);
  assign write_done = bus.dmaAxiWriteReady && bus.dmaAxiWriteReadyData;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    data_d      = data_q;
    rem_d       = rem_q;
    abort_d     = abort_q;
    grant_d     = (grant_q != '0) ? grant_q - 1'b1 : grant_q;
    set_done    = 1'b0;
    set_error   = 1'b0;
    set_aborted = 1'b0;
    clr_status  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (bad_cfg) begin
            set_error = 1'b1;
          end else if (cfg_len == '0) begin
            set_done = 1'b1;
          end else begin
            src_d      = cfg_src;
            dst_d      = cfg_dst;
            rem_d      = cfg_len;
            grant_d    = GW_LOAD;
            abort_d    = 1'b0;
            clr_status = 1'b1;
            state_d    = READ;
          end
        end
      end
      READ: begin
        if (abort) abort_d = 1'b1;
        if (read_done) begin
          data_d  = bus.dmaAxiReadData;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (abort) abort_d = 1'b1;
        if (write_done) begin
          src_d = src_q + 32'd4;
          dst_d = dst_q + 32'd4;
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            set_done = 1'b1;
            state_d  = DONE;
          end else if (abort_q || abort) begin
            set_aborted = 1'b1;
            abort_d     = 1'b0;
            state_d     = IDLE;
          end else begin
            state_d = READ;
          end
        end
      end
      DONE: begin
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetActiveLow) begin
    if (!resetActiveLow) begin
      state_q <= IDLE;
      src_q   <= 32'h0;
      dst_q   <= 32'h0;
      data_q  <= 32'h0;
      rem_q   <= '0;
      grant_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      grant_q <= grant_d;
      abort_q <= abort_d;
    end
  end

  assign bus.regWriteReady        = 1'b1;
  assign bus.regWriteReadyData    = 1'b1;
  assign bus.regReadReady         = 1'b1;
  assign bus.regReadValidData     = 1'b1;
  assign bus.dmaAxiReadReadyData  = 1'b1;
  assign bus.dmaAxiReadValid      = (state_q == READ);
  assign bus.dmaAxiReadAddress    = src_q;
  assign bus.dmaAxiWriteValid     = (state_q == WRITE);
  assign bus.dmaAxiWriteValidData = (state_q == WRITE);
  assign bus.dmaAxiWriteAddress   = dst_q;
  assign bus.dmaAxiWriteData      = data_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_controller.sv
`default_nettype none
// +-------------------------------------------------------------+
// | tb_dma_controller: randomized copy jobs vs. reference model  |
// | rev 1.0                                                      |
// +-------------------------------------------------------------+
module tb_dma_controller;
  localparam int GW = 1;

  logic clock = 1'b0;
  logic resetActiveLow = 1'b0;
  always #5 clock = ~clock;

  dma_controller_if bus ();

  dma_controller #(.GRANT_WAIT(GW), .LEN_W(16)) dut (
    .clock          (clock),
    .resetActiveLow (resetActiveLow),
    .bus            (bus.slave)
  );

  logic [31:0] mem [0:1023];
  assign bus.dmaAxiReadData = mem[bus.dmaAxiReadAddress[11:2]];

  int compared = 0;
  int mismatched = 0;
  int valid_cycles = 0;
  always @(negedge clock) if (bus.dmaAxiReadValid || bus.dmaAxiWriteValid) valid_cycles++;

  // Reference model of the programmer-visible state
  logic [31:0] m_src, m_dst;
  logic [15:0] m_len, m_rem;
  logic        m_irq, m_done, m_err, m_abt;
  logic [31:0] ref_src [0:15];

  function automatic logic [31:0] m_status();
    return {m_rem, 12'h000, m_abt, m_err, m_done, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic reg_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clock);
    bus.regWriteAddress   = addr;
    bus.regWriteData      = data;
    bus.regWriteValid     = 1'b1;
    bus.regWriteValidData = 1'b1;
    @(negedge clock);
    bus.regWriteValid     = 1'b0;
    bus.regWriteValidData = 1'b0;
  endtask

  // Register write plus its effect on the model (engine idle in every call).
  task automatic mreg_write(input logic [31:0] addr, input logic [31:0] data);
    reg_write(addr, data);
    case (addr[4:2])
      3'd0: m_src = data;
      3'd1: m_dst = data;
      3'd2: m_len = data[15:0];
      3'd3: begin
        m_irq = data[1];
        if (data[0]) begin
          if (m_src[30:29] == 2'b00 || m_src[1:0] != 2'b00 || m_dst[1:0] != 2'b00) m_err = 1'b1;
          else if (m_len == 16'd0) m_done = 1'b1;
          else begin
            m_done = 1'b0; m_err = 1'b0; m_abt = 1'b0; m_rem = m_len;
          end
        end
      end
      3'd4: begin
        if (data[1]) m_done = 1'b0;
        if (data[2]) m_err  = 1'b0;
        if (data[3]) m_abt  = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic reg_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clock);
    bus.regReadAddress = addr;
    #1;
    data = bus.regReadData;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] v;
    reg_read(32'h00, v); check({tag, "_src"}, v, m_src);
    reg_read(32'h04, v); check({tag, "_dst"}, v, m_dst);
    reg_read(32'h08, v); check({tag, "_len"}, v, {16'h0, m_len});
    reg_read(32'h0C, v); check({tag, "_ctrl"}, v, {30'h0, m_irq, 1'b0});
    reg_read(32'h10, v); check({tag, "_status"}, v, m_status());
    reg_read(32'h1C, v); check({tag, "_unmapped"}, v, 32'h0);
    check({tag, "_irq"}, {31'h0, bus.doneIrq}, {31'h0, m_done & m_irq});
  endtask

  task automatic fill();
    logic [31:0] v;
    for (int k = 0; k < 16; k++) begin
      v = $urandom;
      ref_src[k] = v;
      mem[m_src[11:2] + 10'(k)] = v;
      mem[m_dst[11:2] + 10'(k)] = 32'hDEAD_0000 | 32'(k);
    end
  endtask

  task automatic check_copy(input string tag, input int copied);
    int bad;
    logic [31:0] exp;
    bad = 0;
    for (int k = 0; k < copied + 2; k++) begin
      exp = (k < copied) ? ref_src[k] : (32'hDEAD_0000 | 32'(k));
      if (mem[m_dst[11:2] + 10'(k)] !== exp) bad++;
    end
    check(tag, 32'(bad), 32'h0);
  endtask

  // Plays the interconnect from the cycle after start until both valids drop.
  task automatic run_job(input bit stall, input int abort_after,
                         output int req, output int writes, output int errs);
    logic        prev_rs, prev_ws;
    logic [31:0] prev_ra, prev_wa, prev_wd;
    bit          sent, fin;
    req = 0; writes = 0; errs = 0;
    prev_rs = 1'b0; prev_ws = 1'b0; prev_ra = '0; prev_wa = '0; prev_wd = '0;
    sent = 1'b0; fin = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (abort_after >= 0 && writes == abort_after && !sent) begin
        bus.regWriteAddress = 32'h0C; bus.regWriteData = 32'h4;
        bus.regWriteValid = 1'b1; bus.regWriteValidData = 1'b1;
        sent = 1'b1;
      end else begin
        bus.regWriteValid = 1'b0; bus.regWriteValidData = 1'b0;
      end
      bus.dmaAxiReadReady      = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.dmaAxiReadValidData  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.dmaAxiWriteReady     = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.dmaAxiWriteReadyData = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.regReadAddress = 32'h10;
      #1;
      if (!bus.dmaAxiReadValid && !bus.dmaAxiWriteValid) begin
        fin = 1'b1;
      end else begin
        req++;
        if (!bus.regReadData[0]) errs++;
        if (bus.dmaAxiReadValid && bus.dmaAxiWriteValid) errs++;
        if (prev_rs && !(bus.dmaAxiReadValid && bus.dmaAxiReadAddress == prev_ra)) errs++;
        if (prev_ws && !(bus.dmaAxiWriteValid && bus.dmaAxiWriteAddress == prev_wa &&
                         bus.dmaAxiWriteData == prev_wd)) errs++;
        if (bus.dmaAxiReadValid && bus.dmaAxiReadAddress != m_src + 32'(4 * writes)) errs++;
        prev_rs = bus.dmaAxiReadValid && !(bus.dmaAxiReadReady && bus.dmaAxiReadValidData);
        prev_ra = bus.dmaAxiReadAddress;
        prev_ws = 1'b0;
        if (bus.dmaAxiWriteValid) begin
          if (!bus.dmaAxiWriteValidData) errs++;
          if (bus.dmaAxiWriteAddress != m_dst + 32'(4 * writes) ||
              bus.dmaAxiWriteData != ref_src[writes]) errs++;
          if (bus.dmaAxiWriteReady && bus.dmaAxiWriteReadyData) begin
            mem[bus.dmaAxiWriteAddress[11:2]] = bus.dmaAxiWriteData;
            writes++;
          end else begin
            prev_ws = 1'b1;
          end
          prev_wa = bus.dmaAxiWriteAddress;
          prev_wd = bus.dmaAxiWriteData;
        end
        @(negedge clock);
      end
    end
    bus.regWriteValid = 1'b0; bus.regWriteValidData = 1'b0;
    bus.dmaAxiReadReady = 1'b1; bus.dmaAxiReadValidData = 1'b1;
    bus.dmaAxiWriteReady = 1'b1; bus.dmaAxiWriteReadyData = 1'b1;
    if (!fin) check("job_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    int req, wr, errs, base, len;
    bit stall, found;
    logic [31:0] v;

    bus.regWriteAddress = '0; bus.regWriteData = '0;
    bus.regWriteValid = 1'b0; bus.regWriteValidData = 1'b0;
    bus.regReadAddress = '0; bus.regReadValid = 1'b1; bus.regReadReadyData = 1'b1;
    bus.dmaAxiReadReady = 1'b1; bus.dmaAxiReadValidData = 1'b1;
    bus.dmaAxiWriteReady = 1'b1; bus.dmaAxiWriteReadyData = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    m_src = '0; m_dst = '0; m_len = '0; m_rem = '0;
    m_irq = 1'b0; m_done = 1'b0; m_err = 1'b0; m_abt = 1'b0;

    #1;
    check("rst_rvalid", {31'h0, bus.dmaAxiReadValid}, 32'h0);
    check("rst_wvalid", {31'h0, bus.dmaAxiWriteValid}, 32'h0);
    check("rst_raddr", bus.dmaAxiReadAddress, 32'h0);
    check("rst_waddr", bus.dmaAxiWriteAddress, 32'h0);
    check("rst_wdata", bus.dmaAxiWriteData, 32'h0);
    @(negedge clock); @(negedge clock);
    resetActiveLow = 1'b1;
    check_regs("reset");

    // Basic 4-word copy with always-ready slaves
    mreg_write(32'h00, 32'h2000_0000);
    mreg_write(32'h04, 32'h2000_0100);
    mreg_write(32'h08, 32'd4);
    fill();
    mreg_write(32'h0C, 32'h1);
    run_job(1'b0, -1, req, wr, errs);
    m_rem = 16'd0; m_done = 1'b1;
    check("basic_req_cycles", 32'(req), 32'(GW + 2 * 4));
    check("basic_writes", 32'(wr), 32'd4);
    check("basic_protocol", 32'(errs), 32'h0);
    reg_read(32'h10, v); check("basic_status", v, m_status());
    check_copy("basic_copy", 4);

    // ROM source: error, no traffic
    v = 32'(valid_cycles);
    mreg_write(32'h00, 32'h0000_0010);
    mreg_write(32'h0C, 32'h1);
    for (int i = 0; i < 5; i++) @(negedge clock);
    check("rom_no_traffic", 32'(valid_cycles) - v, 32'h0);
    check_regs("rom");
    mreg_write(32'h10, 32'h6);
    reg_read(32'h10, v); check("w1c_status", v, m_status());

    // LEN=0 with irq enabled: done immediately, then W1C
    mreg_write(32'h00, 32'h2000_0000);
    mreg_write(32'h08, 32'd0);
    v = 32'(valid_cycles);
    mreg_write(32'h0C, 32'h3);
    bus.regReadAddress = 32'h10; #1;
    check("len0_status", bus.regReadData, m_status());
    check("len0_irq", {31'h0, bus.doneIrq}, 32'h1);
    mreg_write(32'h10, 32'h2);
    check_regs("len0_w1c");
    check("len0_no_traffic", 32'(valid_cycles) - v, 32'h0);

    // Randomised jobs, some with random backpressure
    for (int j = 0; j < 4; j++) begin
      base  = $urandom_range(0, 63);
      len   = (j == 0) ? 8 : $urandom_range(1, 8);
      stall = (j == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      mreg_write(32'h00, 32'h2000_0200 + 32'(4 * base));
      mreg_write(32'h04, 32'h2000_0600 + 32'(4 * $urandom_range(0, 63)));
      mreg_write(32'h08, 32'(len));
      fill();
      mreg_write(32'h0C, 32'h1);
      run_job(stall, -1, req, wr, errs);
      m_rem = 16'd0; m_done = 1'b1;
      check("rand_writes", 32'(wr), 32'(len));
      check("rand_protocol", 32'(errs), 32'h0);
      if (!stall) check("rand_req_cycles", 32'(req), 32'(GW + 2 * len));
      reg_read(32'h10, v); check("rand_status", v, m_status());
      check_copy("rand_copy", len);
    end

    // Abort after the third write: fourth beat still finishes
    mreg_write(32'h00, 32'h2000_0800);
    mreg_write(32'h04, 32'h2000_0A00);
    mreg_write(32'h08, 32'd8);
    fill();
    mreg_write(32'h0C, 32'h3);
    run_job(1'b0, 3, req, wr, errs);
    m_irq = 1'b0; m_abt = 1'b1; m_rem = m_len - 16'd4;
    check("abort_writes", 32'(wr), 32'd4);
    check("abort_protocol", 32'(errs), 32'h0);
    check_regs("abort");
    check_copy("abort_copy", 4);

    // Reset asserted during the first WRITE
    mreg_write(32'h00, 32'h2000_0000);
    mreg_write(32'h04, 32'h2000_0C00);
    mreg_write(32'h08, 32'd4);
    mreg_write(32'h0C, 32'h1);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      #1;
      if (bus.dmaAxiWriteValid) found = 1'b1;
      else @(negedge clock);
    end
    check("rst_reach_write", {31'h0, found}, 32'h1);
    resetActiveLow = 1'b0;
    #1;
    check("midrst_rvalid", {31'h0, bus.dmaAxiReadValid}, 32'h0);
    check("midrst_wvalid", {31'h0, bus.dmaAxiWriteValid | bus.dmaAxiWriteValidData}, 32'h0);
    @(negedge clock);
    resetActiveLow = 1'b1;
    m_src = '0; m_dst = '0; m_len = '0; m_rem = '0;
    m_irq = 1'b0; m_done = 1'b0; m_err = 1'b0; m_abt = 1'b0;
    check_regs("midrst");
    check("midrst_waddr", bus.dmaAxiWriteAddress, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
